// File: rtl/key_gpio_conditioner.sv
// key_gpio_conditioner: conditions the raw active-low board push-buttons for the
// gpio0_i status byte. Each key gets a 2-FF synchroniser, a four-state
// counter-based debounce FSM, and sticky press/release flags. Software clears a
// key's flags with a rising edge on its evt_clr_i bit.
// Optional feature: define KEY_GPIO_CONDITIONER_LONGPRESS_EN to add a per-key
// long-press counter and flag. When it is undefined, the long-press field of
// gpio_o is tied to 0.
module key_gpio_conditioner #(
  parameter int unsigned NKEYS        = 2,
  parameter int unsigned CLK_FREQ_HZ  = 24000000,
  parameter int unsigned DEBOUNCE_MS  = 10,
  parameter int unsigned LONGPRESS_MS = 1000
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [NKEYS-1:0]     key_n_i,
  input  logic [NKEYS-1:0]     evt_clr_i,
  output logic [4*NKEYS-1:0]   gpio_o
);

  localparam int unsigned DB_CYCLES = CLK_FREQ_HZ / 1000 * DEBOUNCE_MS;
  localparam int unsigned LP_CYCLES = CLK_FREQ_HZ / 1000 * LONGPRESS_MS;
  localparam int unsigned DB_W      = $clog2(DB_CYCLES) + 1;
`ifdef KEY_GPIO_CONDITIONER_LONGPRESS_EN
  localparam int unsigned LP_W      = $clog2(LP_CYCLES) + 1;
`endif

  typedef enum logic [1:0] {
    ST_UP        = 2'd0,
    ST_UP_PEND   = 2'd1,
    ST_DOWN      = 2'd2,
    ST_DOWN_PEND = 2'd3
  } key_state_t;

  // Reject configurations where the counters cannot reach their terminal values.
  if (NKEYS < 1 || NKEYS > 2) begin : g_bad_nkeys
    $error("key_gpio_conditioner: NKEYS must be 1 or 2");
  end
  if (DB_CYCLES < 2 || LP_CYCLES < 2) begin : g_bad_cycles
    $error("key_gpio_conditioner: debounce and long-press times must be at least 2 cycles");
  end

  logic [NKEYS-1:0] sync1;
  logic [NKEYS-1:0] sync2;
  logic [NKEYS-1:0] clr_q;
  logic [NKEYS-1:0] clr_rise;

  // Two-flop synchroniser; reset to 1 so a held key restarts as released.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      sync1 <= key_n_i;
      sync2 <= sync1;
    end
  end

  // Registered copy of the clear request for rising-edge detection.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      clr_q <= '0;
    end else begin
      clr_q <= evt_clr_i;
    end
  end

  assign clr_rise = evt_clr_i & ~clr_q;

  for (genvar k = 0; k < NKEYS; k++) begin : g_key
    key_state_t      state;
    logic [DB_W-1:0] db_cnt;
    logic            level;
    logic            press_flag;
    logic            release_flag;
`ifdef KEY_GPIO_CONDITIONER_LONGPRESS_EN
    logic [LP_W-1:0] lp_cnt;
    logic            long_flag;
`endif

    // Debounce FSM plus sticky flags; a set later in the block overrides a clear.
    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        state        <= ST_UP;
        db_cnt       <= '0;
        level        <= 1'b0;
        press_flag   <= 1'b0;
        release_flag <= 1'b0;
`ifdef KEY_GPIO_CONDITIONER_LONGPRESS_EN
        lp_cnt       <= '0;
        long_flag    <= 1'b0;
`endif
      end else begin
        if (clr_rise[k]) begin
          press_flag   <= 1'b0;
          release_flag <= 1'b0;
`ifdef KEY_GPIO_CONDITIONER_LONGPRESS_EN
          long_flag    <= 1'b0;
`endif
        end

        case (state)
          ST_UP: begin
            if (!sync2[k]) begin
              state  <= ST_UP_PEND;
              db_cnt <= DB_W'(1);
            end
          end

          ST_UP_PEND: begin
            if (sync2[k]) begin
              state  <= ST_UP;
              db_cnt <= '0;
            end else if (db_cnt == DB_W'(DB_CYCLES - 1)) begin
              state      <= ST_DOWN;
              db_cnt     <= '0;
              level      <= 1'b1;
              press_flag <= 1'b1;
            end else begin
              db_cnt <= db_cnt + DB_W'(1);
            end
          end

          ST_DOWN: begin
            if (sync2[k]) begin
              state  <= ST_DOWN_PEND;
              db_cnt <= DB_W'(1);
            end
`ifdef KEY_GPIO_CONDITIONER_LONGPRESS_EN
            // Long counter saturates at LP_CYCLES-1 so the flag fires once per press.
            if (lp_cnt != LP_W'(LP_CYCLES - 1)) begin
              lp_cnt <= lp_cnt + LP_W'(1);
              if (lp_cnt == LP_W'(LP_CYCLES - 2)) begin
                long_flag <= 1'b1;
              end
            end
`endif
          end

          ST_DOWN_PEND: begin
            if (!sync2[k]) begin
              state  <= ST_DOWN;
              db_cnt <= '0;
            end else if (db_cnt == DB_W'(DB_CYCLES - 1)) begin
              state        <= ST_UP;
              db_cnt       <= '0;
              level        <= 1'b0;
              release_flag <= 1'b1;
`ifdef KEY_GPIO_CONDITIONER_LONGPRESS_EN
              lp_cnt       <= '0;
`endif
            end else begin
              db_cnt <= db_cnt + DB_W'(1);
            end
          end

          default: begin
            state  <= ST_UP;
            db_cnt <= '0;
          end
        endcase
      end
    end

    // Pack this key's status into the gpio byte.
    assign gpio_o[k]           = level;
    assign gpio_o[NKEYS + k]   = press_flag;
    assign gpio_o[2*NKEYS + k] = release_flag;
`ifdef KEY_GPIO_CONDITIONER_LONGPRESS_EN
    assign gpio_o[3*NKEYS + k] = long_flag;
`else
    assign gpio_o[3*NKEYS + k] = 1'b0;
`endif
  end

endmodule

// File: tb/tb_key_gpio_conditioner.sv
// Directed bench for key_gpio_conditioner with DB_CYCLES=1000, LP_CYCLES=5000.
// Inputs change 1 time unit after a rising edge; "edge n" is the n-th rising
// edge after that change, and outputs are sampled 1 time unit after it.
module tb_key_gpio_conditioner;

  localparam int unsigned NKEYS = 2;

`ifdef KEY_GPIO_CONDITIONER_LONGPRESS_EN
  localparam logic LP_EN = 1'b1;
`else
  localparam logic LP_EN = 1'b0;
`endif

  logic             clock;
  logic             reset_n;
  logic [NKEYS-1:0] key_n_i;
  logic [NKEYS-1:0] evt_clr_i;
  logic [4*NKEYS-1:0] gpio_o;

  int n_checks;
  int n_errors;

  key_gpio_conditioner #(
    .NKEYS        (NKEYS),
    .CLK_FREQ_HZ  (1000000),
    .DEBOUNCE_MS  (1),
    .LONGPRESS_MS (5)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .key_n_i   (key_n_i),
    .evt_clr_i (evt_clr_i),
    .gpio_o    (gpio_o)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance n rising edges, then step past the edge for sampling/driving.
  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 8'h%02h expected 8'h%02h", tag, obs, exp);
    end
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    reset_n   = 1'b0;
    key_n_i   = 2'b11;
    evt_clr_i = 2'b00;

    // Reset with idle keys
    tick(3);
    check("reset", gpio_o, 8'h00);
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick(1000);
      check("idle", gpio_o, 8'h00);
    end

    // Bounce on key1: 300-cycle segments, never stable long enough
    for (int i = 0; i < 10; i++) begin
      key_n_i[1] = (i % 2 == 1);
      tick(300);
    end
    tick(1100);
    check("bounce", gpio_o, 8'h00);

    // Clean press of key0: change lands exactly on edge 1002
    key_n_i[0] = 1'b0;
    tick(1001);
    check("press_e1001", gpio_o, 8'h00);
    tick(1);
    check("press_e1002", gpio_o, 8'h05);

    // Release of key0
    key_n_i[0] = 1'b1;
    tick(1001);
    check("release_e1001", gpio_o, 8'h05);
    tick(1);
    check("release_e1002", gpio_o, 8'h14);

    // Clear pulse takes effect on the next edge; then held clear must not block a set
    evt_clr_i[0] = 1'b1;
    tick(1);
    check("clr_pulse", gpio_o, 8'h00);
    key_n_i[0] = 1'b0;
    tick(1002);
    check("press_clr_held", gpio_o, 8'h05);
    key_n_i[0] = 1'b1;
    tick(1002);
    check("release_clr_held", gpio_o, 8'h14);
    evt_clr_i[0] = 1'b0;
    tick(2);
    check("clr_fall_noop", gpio_o, 8'h14);

    // Collision: clear edge coincides with the press-flag set on edge 1002
    key_n_i[0] = 1'b0;
    tick(1001);
    check("collide_pre", gpio_o, 8'h14);
    evt_clr_i[0] = 1'b1;
    tick(1);
    check("collide", gpio_o, 8'h05);
    evt_clr_i[0] = 1'b0;
    key_n_i[0] = 1'b1;
    tick(1002);
    check("collide_rel", gpio_o, 8'h14);
    evt_clr_i[0] = 1'b1;
    tick(1);
    check("clr0", gpio_o, 8'h00);
    evt_clr_i[0] = 1'b0;

    // Long press on key1, held 7000 cycles
    key_n_i[1] = 1'b0;
    tick(1002);
    check("lp_press", gpio_o, 8'h0A);
    tick(4998);
    check("lp_e6000", gpio_o, 8'h0A);
    tick(1);
    check("lp_e6001", gpio_o, LP_EN ? 8'h8A : 8'h0A);
    tick(999);
    check("lp_e7000", gpio_o, LP_EN ? 8'h8A : 8'h0A);
    key_n_i[1] = 1'b1;
    tick(1002);
    check("lp_release", gpio_o, LP_EN ? 8'hA8 : 8'h28);
    evt_clr_i[1] = 1'b1;
    tick(1);
    check("clr1", gpio_o, 8'h00);
    evt_clr_i[1] = 1'b0;

    // Simultaneous press and release of both keys
    key_n_i = 2'b00;
    tick(1002);
    check("both_press", gpio_o, 8'h0F);
    key_n_i = 2'b11;
    tick(1002);
    check("both_release", gpio_o, 8'h3C);
    evt_clr_i = 2'b11;
    tick(1);
    check("clr_both", gpio_o, 8'h00);
    evt_clr_i = 2'b00;

    // Boundary pulses: 999 cycles is rejected, 1000 cycles is accepted
    key_n_i[0] = 1'b0;
    tick(999);
    key_n_i[0] = 1'b1;
    tick(1200);
    check("pulse_999", gpio_o, 8'h00);
    key_n_i[0] = 1'b0;
    tick(1000);
    key_n_i[0] = 1'b1;
    tick(2);
    check("pulse_1000", gpio_o, 8'h05);
    tick(1100);
    check("pulse_1000_rel", gpio_o, 8'h14);

    // Key held through reset: press reported 1002 edges after reset release
    key_n_i[0] = 1'b0;
    reset_n    = 1'b0;
    tick(3);
    check("held_reset", gpio_o, 8'h00);
    reset_n = 1'b1;
    tick(1001);
    check("held_e1001", gpio_o, 8'h00);
    tick(1);
    check("held_e1002", gpio_o, 8'h05);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
